// File: rtl/muldiv_if.sv
// Request/response bundle between the issue stage and the iterative multiply/divide unit.
// The slave side is the unit. The master side is the issuing stage or the testbench.
interface muldiv_if #(
    parameter int REG_WIDTH = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [REG_WIDTH-1:0] rs1_val;
    logic [REG_WIDTH-1:0] rs2_val;
    logic [4:0]           rd_in;
    logic                 flush;
    logic                 out_valid;
    logic [4:0]           out_rd;
    logic [REG_WIDTH-1:0] out_result;
    logic                 out_reg_write;

    modport master (
        output in_valid, op, rs1_val, rs2_val, rd_in, flush,
        input  in_ready, out_valid, out_rd, out_result, out_reg_write
    );

    modport slave (
        input  in_valid, op, rs1_val, rs2_val, rd_in, flush,
        output in_ready, out_valid, out_rd, out_result, out_reg_write
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: one bit per cycle on magnitudes, with sign fix-up afterwards.
// Fixed latency of REG_WIDTH+2 edges from acceptance to the result strobe. One operation is in flight at a time.
module muldiv_unit #(
    parameter int REG_WIDTH = 64
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);
    localparam int W  = REG_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [2:0]      op_reg;
    logic [4:0]      rd_reg;
    logic [W-1:0]    a_orig_reg;
    logic [W-1:0]    opnd_reg;
    logic [2*W-1:0]  acc_reg;
    logic            neg_reg;
    logic            rem_neg_reg;
    logic            div_zero_reg;
    logic            ovf_reg;
    logic            out_valid_reg;
    logic            out_reg_write_reg;
    logic [4:0]      out_rd_reg;
    logic [W-1:0]    out_result_reg;

    // Operand preparation at acceptance
    logic            fire;
    logic            is_div;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;

    assign fire     = (state_reg == IDLE) && bus.in_valid && !bus.flush;
    assign is_div   = bus.op[2];
    assign a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign a_neg    = a_signed && bus.rs1_val[W-1];
    assign b_neg    = b_signed && bus.rs2_val[W-1];
    assign a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
    assign b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;

    // The accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [W:0]      mul_sum;
    logic [W:0]      div_shifted;
    logic            div_ge;
    logic [W-1:0]    div_diff;
    logic [2*W-1:0]  acc_step;

    always_comb begin
        mul_sum     = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shifted = {acc_reg[2*W-1:W], acc_reg[W-1]};
        div_ge      = div_shifted >= {1'b0, opnd_reg};
        div_diff    = div_shifted[W-1:0] - opnd_reg;
        if (op_reg[2]) begin
            if (div_ge)
                acc_step = {div_diff, acc_reg[W-2:0], 1'b1};
            else
                acc_step = {div_shifted[W-1:0], acc_reg[W-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_reg[W-1:1]};
        end
    end

    // High half of the negated double-width product: ~hi plus the carry out of the low half
    logic            lo_zero;
    logic [W-1:0]    prod_hi;
    logic [W-1:0]    quot, rem;
    logic [W-1:0]    fix_result;

    always_comb begin
        lo_zero    = (acc_reg[W-1:0] == '0);
        prod_hi    = neg_reg ? (~acc_reg[2*W-1:W] + {{(W-1){1'b0}}, lo_zero}) : acc_reg[2*W-1:W];
        quot       = neg_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
        rem        = rem_neg_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
        fix_result = '0;
        case (op_reg)
            3'd0:                fix_result = acc_reg[W-1:0];
            3'd1, 3'd2, 3'd3:    fix_result = prod_hi;
            3'd4, 3'd5: begin
                if (div_zero_reg)      fix_result = '1;
                else if (ovf_reg)      fix_result = a_orig_reg;
                else                   fix_result = quot;
            end
            default: begin
                if (div_zero_reg)      fix_result = a_orig_reg;
                else if (ovf_reg)      fix_result = '0;
                else                   fix_result = rem;
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.in_valid) state_next = CALC;
                CALC:    if (cnt_reg == '0) state_next = FIX;
                FIX:     state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg      <= '0;
            op_reg       <= '0;
            rd_reg       <= '0;
            a_orig_reg   <= '0;
            opnd_reg     <= '0;
            acc_reg      <= '0;
            neg_reg      <= 1'b0;
            rem_neg_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            ovf_reg      <= 1'b0;
        end else if (fire) begin
            cnt_reg      <= CW'(W - 1);
            op_reg       <= bus.op;
            rd_reg       <= bus.rd_in;
            a_orig_reg   <= bus.rs1_val;
            acc_reg      <= is_div ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
            opnd_reg     <= is_div ? b_mag : a_mag;
            neg_reg      <= a_neg ^ b_neg;
            rem_neg_reg  <= a_neg;
            div_zero_reg <= (bus.rs2_val == '0);
            ovf_reg      <= is_div && a_signed && (bus.rs1_val == {1'b1, {(W-1){1'b0}}})
                            && (bus.rs2_val == '1);
        end else if (state_reg == CALC) begin
            acc_reg      <= acc_step;
            cnt_reg      <= cnt_reg - 1'b1;
        end
    end

    // The result registers load in FIX, so the values are visible during DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg     <= 1'b0;
            out_reg_write_reg <= 1'b0;
            out_rd_reg        <= '0;
            out_result_reg    <= '0;
        end else if (state_reg == FIX && !bus.flush) begin
            out_valid_reg     <= 1'b1;
            out_reg_write_reg <= (rd_reg != 5'd0);
            out_rd_reg        <= rd_reg;
            out_result_reg    <= fix_result;
        end else begin
            out_valid_reg     <= 1'b0;
            out_reg_write_reg <= 1'b0;
        end
    end

    assign bus.in_ready      = (state_reg == IDLE);
    assign bus.out_valid     = out_valid_reg;
    assign bus.out_reg_write = out_reg_write_reg;
    assign bus.out_rd        = out_rd_reg;
    assign bus.out_result    = out_result_reg;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide execution unit, downstream of the register file.
- Consumes the two source operand values (rs1/rs2 data) plus the destination index.
- Produces a destination index, a result, and a write-enable, which drive the register file write port (rd, rd_din, reg_write) directly.
- Fixed-latency, one operation in flight, valid/ready handshake on the input side.

Parameters:
REG_WIDTH, 64, operand/result width in bits; even, >= 8; iteration count equals REG_WIDTH.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  unit idle, request accepted this cycle if in_valid=1
op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_val  input  REG_WIDTH  operand A (multiplicand / dividend)
rs2_val  input  REG_WIDTH  operand B (multiplier / divisor)
rd_in  input  5  destination register index
flush  input  1  abort in-flight operation (pipeline kill)
out_valid  output  1  one-cycle result strobe
out_rd  output  5  destination index of result
out_result  output  REG_WIDTH  result value
out_reg_write  output  1  out_valid AND (out_rd != 0)

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset_n).
- While reset_n=0, all state and outputs clear:
  - state=IDLE, in_ready=1, out_valid=0, out_reg_write=0, out_rd=0, out_result=0.
- All outputs are registered; in_ready is decoded from the state register only (no combinational in-to-out path).
- FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE: in_ready=1. On an edge with in_valid=1, the unit latches op, rd_in and operands, then enters CALC with iteration counter = REG_WIDTH-1.
- Operand preparation at acceptance:
  - Signed operands (MULH A and B; MULHSU A only; DIV/REM both) are converted to magnitude, and the result sign is recorded.
  - For MUL, the low half is sign-agnostic, so MUL uses the unsigned path.
- CALC: one iteration per cycle for exactly REG_WIDTH cycles; the counter decrements and CALC exits after the iteration at count 0.
  - Multiply: shift-add into a 2*REG_WIDTH product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX (1 cycle): apply sign correction and select the result.
  - MUL: low half of product. MULH/MULHSU/MULHU: high half of the (two's-complement negated if needed) 2*REG_WIDTH product.
  - DIV: quotient negated if signs differ. REM: remainder takes the sign of the dividend.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend (original signed value).
  - Signed overflow (DIV/REM with A = most-negative, B = -1): quotient = A, remainder = 0.
  - These special cases are overrides in FIX; latency is unchanged.
- DONE (1 cycle): out_valid=1, out_result/out_rd hold the result, and out_reg_write is asserted unless out_rd=0. The unit returns to IDLE on the next edge.
- out_valid is 0 in every other state. out_result/out_rd hold their last values when out_valid=0.
- Latency: for acceptance at edge k, out_valid is high in the cycle following edge k+REG_WIDTH+1 (66 cycles for REG_WIDTH=64). in_ready returns to 1 in the cycle after DONE.
- Throughput: one op per REG_WIDTH+3 cycles. in_valid while in_ready=0 is ignored; no request is queued.
- flush=1 on any edge, in any state:
  - next state=IDLE, with no out_valid for the aborted op.
  - flush has priority over acceptance: in IDLE with in_valid=1 and flush=1, nothing is accepted.
  - flush while in DONE is also honoured: out_valid drops on the next edge as normal.
- reset_n assertion mid-operation: immediate return to reset values and no result for the aborted op.

Test Plan:
- Reset, then MUL rs1=7, rs2=6, rd=5 -> exactly one out_valid pulse 66 cycles after acceptance with out_result=42, out_rd=5, out_reg_write=1; in_ready low from acceptance through DONE.
- MULH(-1,-1)=0; MULHU(0xFFFF_FFFF_FFFF_FFFF, 2)=1; MULHSU(-1, 2)=0xFFFF_FFFF_FFFF_FFFF -> values as stated.
- DIV(-7,2)=-3; REM(-7,2)=-1; DIVU(100,7)=14; REMU(100,7)=2 -> values as stated.
- Corner cases, all with the same 66-cycle latency:
  - DIVU(5,0)=0xFFFF_FFFF_FFFF_FFFF; REMU(5,0)=5.
  - DIV(0x8000_0000_0000_0000,-1)=0x8000_0000_0000_0000; REM of the same = 0.
- Issue DIV, hold in_valid with a second op during CALC, then pulse flush at cycle 20 -> no out_valid for either op, in_ready=1 the next cycle, and a fresh MUL(3,3) then yields 9.
- MUL(2,3) with rd=0 -> out_valid=1, out_result=6, out_reg_write=0. Separately, assert reset_n=0 mid-CALC -> all outputs 0 immediately, in_ready=1 after release.
